mux_sel_sequencer: RTL and testbench

- Sequential front-end for the 512:1 select tree.
- Drives the tree's select bus through a programmable address window, one address per cycle.
- Samples the tree's single-bit output on each of those cycles and packs the bits LSB-first into OUT_W-bit words.
- Delivers the words over a valid/ready stream, turning the combinational tree into a streaming bit-reader of its input vector.

---
 rtl/mux_sel_sequencer_if.sv | 36 +++
 rtl/mux_sel_sequencer.sv | 154 +++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_if.sv
// Stream/control bundle between mux_sel_sequencer and its environment.
// master = the sequencer side; slave = the requester, tree and consumer side.
interface mux_sel_sequencer_if #(
  parameter int SEL_W = 9,
  parameter int OUT_W = 8
);
   logic             start;
   logic [SEL_W-1:0] start_addr;
   logic [SEL_W:0]   count;
   logic             busy;
   logic [SEL_W-1:0] sel;
   logic             mux_in;
   logic [OUT_W-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             done;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
   logic             dout_par;
`endif

   modport master (
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
      output dout_par,
`endif
      input  start, start_addr, count, mux_in, dout_ready,
      output busy, sel, dout, dout_valid, done
   );

   modport slave (
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
      input  dout_par,
`endif
      output start, start_addr, count, mux_in, dout_ready,
      input  busy, sel, dout, dout_valid, done
   );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Walks a select window over a 2^SEL_W:1 tree and streams the sampled bits
// as LSB-first OUT_W-bit words. Define MUX_SEL_SEQUENCER_PARITY_EN to add dout_par.
module mux_sel_sequencer #(
  parameter int SEL_W = 9,
  parameter int OUT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mux_sel_sequencer_if.master  bus
);

   localparam int CNT_W = SEL_W + 1;
   localparam int BIT_W = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {SEL_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

   state_t           state;
   logic [SEL_W-1:0] sel_q;
   logic [OUT_W-1:0] shreg;
   logic [BIT_W-1:0] bitcnt;
   logic [CNT_W-1:0] remaining;
   logic [OUT_W-1:0] dout_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
   logic             par_q;
`endif

   logic [BIT_W-1:0] next_bitcnt;
   logic [CNT_W-1:0] next_remaining;
   logic [OUT_W-1:0] sample_word;
   logic [CNT_W-1:0] clamped_count;
   logic             word_done;
   logic             accept;
   logic             out_free;
   logic             load_en;
   logic [OUT_W-1:0] load_word;

   // NOTE: always_comb assigns every output a default first so no latch can be inferred.
   always_comb begin
      next_bitcnt    = bitcnt + BIT_W'(1);
      next_remaining = remaining - CNT_W'(1);
      sample_word    = shreg | (OUT_W'(bus.mux_in) << bitcnt);
      word_done      = (next_bitcnt == BIT_W'(OUT_W)) || (next_remaining == '0);
      accept         = valid_q && bus.dout_ready;
      out_free       = !valid_q || bus.dout_ready;
      clamped_count  = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
      load_en        = 1'b0;
      load_word      = sample_word;
      if (state == RUN && word_done && out_free) begin
         load_en = 1'b1;
      end else if (state == STALL && accept) begin
         load_en   = 1'b1;
         load_word = shreg;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel_q     <= '0;
         shreg     <= '0;
         bitcnt    <= '0;
         remaining <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;

         // Output register: a load may coincide with acceptance of the previous word.
         if (load_en) begin
            dout_q  <= load_word;
            valid_q <= 1'b1;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
            par_q   <= ^load_word;
`endif
         end else if (accept) begin
            valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     sel_q     <= bus.start_addr;
                     remaining <= clamped_count;
                     bitcnt    <= '0;
                     shreg     <= '0;
                     busy_q    <= 1'b1;
                     state     <= RUN;
                  end
               end
            end

            RUN: begin
               // The bit for the current sel is captured on the edge that advances sel.
               sel_q     <= sel_q + SEL_W'(1);
               remaining <= next_remaining;
               if (word_done && out_free) begin
                  shreg  <= '0;
                  bitcnt <= '0;
                  state  <= (next_remaining == '0) ? DRAIN : RUN;
               end else if (word_done) begin
                  shreg  <= sample_word;
                  bitcnt <= next_bitcnt;
                  state  <= STALL;
               end else begin
                  shreg  <= sample_word;
                  bitcnt <= next_bitcnt;
               end
            end

            STALL: begin
               if (accept) begin
                  shreg  <= '0;
                  bitcnt <= '0;
                  state  <= (remaining == '0) ? DRAIN : RUN;
               end
            end

            DRAIN: begin
               if (accept) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel        = sel_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
   assign bus.dout_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer: a 512-bit vector models the tree,
// expected words are queued at launch and matched against accepted words.
module tb_mux_sel_sequencer;
   localparam int SEL_W = 9;
   localparam int OUT_W = 8;
   localparam int N     = 1 << SEL_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_sel_sequencer_if #(.SEL_W(SEL_W), .OUT_W(OUT_W)) bus ();

   logic [N-1:0] tree;
   assign bus.mux_in = tree[bus.sel];

   mux_sel_sequencer #(.SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] obs_q[$];
   logic             par_q[$];
   logic [SEL_W-1:0] sel_log[$];

   int               cyc = 0;
   int               valid_cnt, done_cnt, last_valid_cyc, done_cyc, unstable;
   bit               busy_seen, prev_hold;
   logic [OUT_W-1:0] prev_dout;
   logic [SEL_W-1:0] frozen_sel;

   // Called at a falling edge with inputs settled; observes, then advances one cycle.
   task automatic step();
      cyc++;
      if (bus.dout_valid) begin
         valid_cnt++;
         last_valid_cyc = cyc;
      end
      if (bus.dout_valid && bus.dout_ready) begin
         obs_q.push_back(bus.dout);
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
         par_q.push_back(bus.dout_par);
`endif
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy) begin
         busy_seen = 1'b1;
         sel_log.push_back(bus.sel);
      end
      if (prev_hold && (!bus.dout_valid || bus.dout !== prev_dout)) unstable++;
      prev_hold = bus.dout_valid && !bus.dout_ready;
      prev_dout = bus.dout;
      @(negedge clk);
   endtask

   task automatic randomize_tree();
      for (int i = 0; i < N / 32; i++) tree[i*32 +: 32] = $urandom;
   endtask

   task automatic push_model(input int addr, input int cnt);
      logic [OUT_W-1:0] w;
      int nw;
      nw = (cnt + OUT_W - 1) / OUT_W;
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int b = 0; b < OUT_W; b++)
            if (k * OUT_W + b < cnt) w[b] = tree[(addr + k * OUT_W + b) % N];
         exp_q.push_back(w);
      end
   endtask

   // Launch one scan; optional backpressure window and an ignored mid-scan start.
   task automatic run_scan(input int addr, input int cnt, input int stall_len,
                           input int restart_at, input int budget);
      int stall_left;
      bit stall_started;
      int i;
      stall_left = 0;
      stall_started = 1'b0;
      valid_cnt = 0; done_cnt = 0; unstable = 0; busy_seen = 1'b0;
      prev_hold = 1'b0; frozen_sel = '0;
      sel_log.delete();
      bus.dout_ready = 1'b1;
      bus.start      = 1'b1;
      bus.start_addr = SEL_W'(addr);
      bus.count      = (SEL_W+1)'(cnt);
      step();
      i = 0;
      while (done_cnt == 0 && i < budget) begin
         if (i == restart_at) begin
            bus.start      = 1'b1;
            bus.start_addr = SEL_W'(addr + 37);
            bus.count      = (SEL_W+1)'(3);
         end else begin
            bus.start = 1'b0;
         end
         if (stall_len > 0 && !stall_started && bus.dout_valid) begin
            stall_started = 1'b1;
            stall_left    = stall_len;
         end
         if (stall_left > 0) begin
            bus.dout_ready = 1'b0;
            stall_left--;
            if (stall_left == 0) frozen_sel = bus.sel;
         end else begin
            bus.dout_ready = 1'b1;
         end
         step();
         i++;
      end
      bus.start      = 1'b0;
      bus.dout_ready = 1'b1;
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL scan_timeout addr=%0d count=%0d: no done within %0d cycles", addr, cnt, budget);
      end
      repeat (3) step();
   endtask

   task automatic score_words(input string name);
      logic [OUT_W-1:0] e, o;
      int idx;
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL %s word%0d missing: got none, expected %h", name, idx, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL %s word%0d: got %h, expected %h", name, idx, o, e);
            end
         end
         idx++;
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL %s extra_words: got %0d, expected 0", name, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      checks += 5;
      if (bus.sel !== '0)       begin errors++; $display("FAIL %s sel: got %0d, expected 0", name, bus.sel); end
      if (bus.dout !== '0)      begin errors++; $display("FAIL %s dout: got %h, expected 00", name, bus.dout); end
      if (bus.dout_valid !== 0) begin errors++; $display("FAIL %s dout_valid: got %b, expected 0", name, bus.dout_valid); end
      if (bus.busy !== 0)       begin errors++; $display("FAIL %s busy: got %b, expected 0", name, bus.busy); end
      if (bus.done !== 0)       begin errors++; $display("FAIL %s done: got %b, expected 0", name, bus.done); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check_reset_outputs("reset");
   endtask

   task automatic test_basic();
      randomize_tree();
      tree[7:0] = 8'hA5;
      exp_q.push_back(8'hA5);
      run_scan(0, 8, 0, -1, 40);
      score_words("basic");
      checks += 4;
      if (valid_cnt != 1) begin errors++; $display("FAIL basic valid_cycles: got %0d, expected 1", valid_cnt); end
      if (done_cnt != 1) begin errors++; $display("FAIL basic done_pulses: got %0d, expected 1", done_cnt); end
      if (done_cyc != last_valid_cyc + 1) begin
         errors++; $display("FAIL basic done_timing: got cycle %0d, expected %0d", done_cyc, last_valid_cyc + 1);
      end
      if (bus.sel !== 9'd8) begin errors++; $display("FAIL basic final_sel: got %0d, expected 8", bus.sel); end
   endtask

   task automatic test_wrap();
      int exp_sel[8] = '{508, 509, 510, 511, 0, 1, 2, 3};
      int bad;
      randomize_tree();
      tree[511:508] = 4'hF;
      tree[3:0]     = 4'h0;
      exp_q.push_back(8'h0F);
      run_scan(508, 8, 0, -1, 40);
      score_words("wrap");
      bad = -1;
      checks++;
      if (sel_log.size() < 8) begin
         errors++; $display("FAIL wrap sel_log_len: got %0d, expected >=8", sel_log.size());
      end else begin
         for (int i = 0; i < 8; i++)
            if (bad < 0 && sel_log[i] !== SEL_W'(exp_sel[i])) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++; $display("FAIL wrap sel_seq[%0d]: got %0d, expected %0d", bad, sel_log[bad], exp_sel[bad]);
         end
      end
   endtask

   task automatic test_backpressure();
      randomize_tree();
      push_model(100, 24);
      run_scan(100, 24, 20, -1, 200);
      score_words("backpressure");
      checks += 3;
      if (frozen_sel !== 9'd116) begin errors++; $display("FAIL backpressure frozen_sel: got %0d, expected 116", frozen_sel); end
      if (unstable != 0) begin errors++; $display("FAIL backpressure dout_stable: got %0d changes, expected 0", unstable); end
      if (done_cnt != 1) begin errors++; $display("FAIL backpressure done_pulses: got %0d, expected 1", done_cnt); end
   endtask

   task automatic test_partial_and_zero();
      randomize_tree();
      tree[202:200] = 3'b101;
      exp_q.push_back(8'h05);
      run_scan(200, 3, 0, -1, 20);
      score_words("partial");
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL partial done_pulses: got %0d, expected 1", done_cnt); end
      run_scan(50, 0, 0, -1, 10);
      score_words("zero");
      checks += 3;
      if (valid_cnt != 0) begin errors++; $display("FAIL zero valid_cycles: got %0d, expected 0", valid_cnt); end
      if (busy_seen)      begin errors++; $display("FAIL zero busy: got 1, expected 0"); end
      if (done_cnt != 1)  begin errors++; $display("FAIL zero done_pulses: got %0d, expected 1", done_cnt); end
   endtask

   task automatic test_reset_mid_scan();
      randomize_tree();
      bus.start = 1'b1; bus.start_addr = '0; bus.count = 10'd16; bus.dout_ready = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      done_cnt = 0;
      rst = 1'b1;
      step();
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      repeat (4) step();
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL mid_reset done_pulses: got %0d, expected 0", done_cnt); end
      obs_q.delete();
      push_model(40, 16);
      run_scan(40, 16, 0, -1, 60);
      score_words("after_reset");
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL after_reset done_pulses: got %0d, expected 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      randomize_tree();
      push_model(300, 32);
      run_scan(300, 32, 0, -1, 80);
      score_words("back_to_back");
      checks++;
      if (sel_log.size() != 33) begin
         errors++; $display("FAIL back_to_back busy_cycles: got %0d, expected 33", sel_log.size());
      end
   endtask

   task automatic test_clamp_and_restart();
      randomize_tree();
      push_model(0, 512);
      run_scan(0, 600, 0, 50, 700);
      score_words("clamp");
      checks += 2;
      if (done_cnt != 1) begin errors++; $display("FAIL clamp done_pulses: got %0d, expected 1", done_cnt); end
      if (bus.sel !== '0) begin errors++; $display("FAIL clamp final_sel: got %0d, expected 0", bus.sel); end
   endtask

`ifdef MUX_SEL_SEQUENCER_PARITY_EN
   task automatic test_parity();
      logic p;
      par_q.delete();
      randomize_tree();
      tree[7:0] = 8'hA5;
      exp_q.push_back(8'hA5);
      run_scan(0, 8, 0, -1, 40);
      score_words("parity_a5");
      checks++;
      p = (par_q.size() > 0) ? par_q.pop_front() : 1'bx;
      if (p !== 1'b0) begin errors++; $display("FAIL parity_a5 dout_par: got %b, expected 0", p); end
      tree[2:0] = 3'b111;
      exp_q.push_back(8'h07);
      run_scan(0, 3, 0, -1, 20);
      score_words("parity_07");
      checks++;
      p = (par_q.size() > 0) ? par_q.pop_front() : 1'bx;
      if (p !== 1'b1) begin errors++; $display("FAIL parity_07 dout_par: got %b, expected 1", p); end
   endtask
`endif

   initial begin
      rst            = 1'b1;
      tree           = '0;
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.count      = '0;
      bus.dout_ready = 1'b1;
      prev_hold      = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_partial_and_zero();
      test_reset_mid_scan();
      test_back_to_back();
      test_clamp_and_restart();
`ifdef MUX_SEL_SEQUENCER_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
